// File: rtl/sum_capture_pkg.sv
// Shared constants, FIFO operation encoding and level-next helper for the sum capture FIFO.
// Optional accumulator is enabled with macro SUM_CAPTURE_ACC_EN.
package sum_capture_pkg;

    localparam int unsigned SUM_DW    = 4;
    localparam int unsigned SUM_DEPTH = 4;
    localparam int unsigned ACC_W     = 8;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int unsigned level_next(input int unsigned lvl,
                                               input logic push,
                                               input logic pop);
        fifo_op_e op;
        op = fifo_op_e'({push, pop});
        case (op)
            OP_PUSH: level_next = lvl + 1;
            OP_POP:  level_next = lvl - 1;
            default: level_next = lvl;
        endcase
    endfunction

endpackage

// File: rtl/sum_capture_mem.sv
// DEPTH x DW sample storage: one synchronous write port, one asynchronous read port, no reset.
module sum_capture_mem
    import sum_capture_pkg::*;
#(
    parameter int unsigned DW    = SUM_DW,
    parameter int unsigned DEPTH = SUM_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sum_capture_fifo.sv
// Captures adder sums into a first-word fall-through FIFO with valid/ready output and sticky overflow.
// Define SUM_CAPTURE_ACC_EN to add the running sum of popped samples on port acc.
module sum_capture_fifo
    import sum_capture_pkg::*;
#(
    parameter int unsigned DW    = SUM_DW,
    parameter int unsigned DEPTH = SUM_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_vld,
    input  logic          ovf_clr,
    output logic [DW-1:0] out_data,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic          ovf,
    output logic [AW:0]   level
`ifdef SUM_CAPTURE_ACC_EN
    ,
    output logic [ACC_W-1:0] acc
`endif
);

    localparam int unsigned LW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] rdata;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign out_vld = !empty;
    assign pop     = out_vld && out_rdy;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push    = in_vld && (!full || pop);

    assign out_data = empty ? '0 : rdata;

    sum_capture_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= LW'(level_next(32'(level), push, pop));
        end
    end

    // A fresh drop in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (in_vld && full && !pop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef SUM_CAPTURE_ACC_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (pop) begin
            acc <= acc + ACC_W'(out_data);
        end
    end
`endif

endmodule

// File: tb/tb_sum_capture_fifo.sv
// Scoreboard bench for sum_capture_fifo; expected samples are queued at push and compared at pop.
// Accumulator checks are included when SUM_CAPTURE_ACC_EN is defined.
module tb_sum_capture_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_vld = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] out_data;
    logic       out_vld;
    logic       out_rdy = 1'b0;
    logic       ovf;
    logic [2:0] level;
`ifdef SUM_CAPTURE_ACC_EN
    logic [7:0] acc;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [3:0] sb_q [$];
    logic       m_ovf = 1'b0;
    logic [7:0] m_acc = '0;

    always #5 clk = ~clk;

    sum_capture_fifo #(
        .DW    (4),
        .DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .ovf_clr  (ovf_clr),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .ovf      (ovf),
        .level    (level)
`ifdef SUM_CAPTURE_ACC_EN
        ,
        .acc      (acc)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check pre-edge outputs, advance the model, check post-edge state.
    task automatic cycle(input logic v, input logic [3:0] d, input logic r, input logic c);
        logic m_pop;
        logic m_full;
        in_vld  = v;
        in_data = d;
        out_rdy = r;
        ovf_clr = c;
        #1;
        m_full = (sb_q.size() == 4);
        m_pop  = (sb_q.size() != 0) && r;
        check("out_vld", 32'(out_vld), 32'(sb_q.size() != 0));
        if (m_pop) begin
            logic [3:0] exp_d;
            exp_d = sb_q.pop_front();
            check("out_data", 32'(out_data), 32'(exp_d));
            m_acc = m_acc + 8'(exp_d);
        end else if (sb_q.size() == 0) begin
            check("out_data_empty", 32'(out_data), 32'h0);
        end
        if (v && (!m_full || m_pop)) begin
            sb_q.push_back(d);
        end else if (v && m_full && !m_pop) begin
            m_ovf = 1'b1;
        end else if (c) begin
            m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        check("level", 32'(level), 32'(sb_q.size()));
        check("ovf", 32'(ovf), 32'(m_ovf));
`ifdef SUM_CAPTURE_ACC_EN
        check("acc", 32'(acc), 32'(m_acc));
`endif
    endtask

    task automatic do_reset(input int unsigned n);
        rst    = 1'b0;
        in_vld = 1'b1;
        in_data = 4'h7;
        out_rdy = 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
        rst    = 1'b1;
        in_vld = 1'b0;
        out_rdy = 1'b0;
        sb_q.delete();
        m_ovf = 1'b0;
        m_acc = '0;
        check("rst_level", 32'(level), 32'h0);
        check("rst_out_vld", 32'(out_vld), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
`ifdef SUM_CAPTURE_ACC_EN
        check("rst_acc", 32'(acc), 32'h0);
`endif
    endtask

    task automatic drain();
        for (int unsigned i = 0; i < 8 && sb_q.size() != 0; i++) begin
            cycle(1'b0, 4'h0, 1'b1, 1'b0);
        end
        check("drained", 32'(sb_q.size()), 32'h0);
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
    endtask

    initial begin
        #1;
        do_reset(2);

        // Fill and drain
        for (int unsigned i = 0; i < 4; i++) begin
            cycle(1'b1, 4'(i), 1'b0, 1'b0);
        end
        check("fill_level", 32'(level), 32'h4);
        drain();

        // Overflow then clear
        for (int unsigned i = 0; i < 4; i++) begin
            cycle(1'b1, 4'(i), 1'b0, 1'b0);
        end
        cycle(1'b1, 4'ha, 1'b0, 1'b0);
        check("ovf_set", 32'(ovf), 32'h1);
        check("ovf_level", 32'(level), 32'h4);
        drain();
        check("ovf_sticky", 32'(ovf), 32'h1);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(ovf), 32'h0);

        // Overflow wins over a same-cycle clear
        for (int unsigned i = 0; i < 4; i++) begin
            cycle(1'b1, 4'(i + 4), 1'b0, 1'b0);
        end
        cycle(1'b1, 4'he, 1'b0, 1'b1);
        check("ovf_clr_race", 32'(ovf), 32'h1);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // Full push+pop keeps level and accepts the new sample
        cycle(1'b1, 4'hb, 1'b1, 1'b0);
        check("fullpp_ovf", 32'(ovf), 32'h0);
        check("fullpp_level", 32'(level), 32'h4);
        check("fullpp_head", 32'(out_data), 32'h5);
        drain();

        // Empty with in_vld and out_rdy: push only
        cycle(1'b1, 4'h9, 1'b1, 1'b0);
        check("empty_pushonly", 32'(level), 32'h1);
        // Held in_vld with concurrent pops streams through
        for (int unsigned i = 0; i < 6; i++) begin
            cycle(1'b1, 4'($urandom_range(15)), 1'($urandom_range(1)), 1'b0);
        end
        drain();

        // Mid-stream reset discards buffered data
        cycle(1'b1, 4'h3, 1'b0, 1'b0);
        cycle(1'b1, 4'h4, 1'b0, 1'b0);
        do_reset(1);
        for (int unsigned i = 0; i < 3; i++) begin
            cycle(1'b0, 4'h0, 1'b1, 1'b0);
        end

`ifdef SUM_CAPTURE_ACC_EN
        do_reset(1);
        for (int unsigned i = 0; i < 4; i++) begin
            cycle(1'b1, 4'(4'ha + i), 1'b0, 1'b0);
        end
        drain();
        check("acc_2e", 32'(acc), 32'h2e);
        do_reset(1);
        for (int unsigned j = 0; j < 4; j++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cycle(1'b1, 4'hf, 1'b0, 1'b0);
            end
            drain();
        end
        check("acc_wrap", 32'(acc), 32'hf0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
